// File: rtl/spi_pkg.sv
// Shared encodings and helpers for the parametrised SPI master.
package spi_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLead  = 3'd1;
  localparam logic [2:0] StXfer  = 3'd2;
  localparam logic [2:0] StTrail = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  // SPI mode as {cpol, cpha}
  localparam logic [1:0] Mode0 = 2'b00;
  localparam logic [1:0] Mode1 = 2'b01;
  localparam logic [1:0] Mode2 = 2'b10;
  localparam logic [1:0] Mode3 = 2'b11;

  function automatic int unsigned edge_cnt_w(input int unsigned data_w);
    return $clog2(2 * data_w + 1);
  endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Command and SPI pin bundle; master is the controller side, slave the environment side.
interface spi_master_param_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_CS   = 1,
  parameter int unsigned CS_SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
  logic                start;
  logic                cpol;
  logic                cpha;
  logic                lsb_first;
  logic [CS_SEL_W-1:0] cs_sel;
  logic [DATA_W-1:0]   data_in;
  logic [DATA_W-1:0]   data_out;
  logic                busy;
  logic                done;
  logic                miso;
  logic                mosi;
  logic                sck;
  logic [NUM_CS-1:0]   cs_n;

  modport master (
    input  start, cpol, cpha, lsb_first, cs_sel, data_in, miso,
    output mosi, sck, cs_n, data_out, busy, done
  );

  modport slave (
    output start, cpol, cpha, lsb_first, cs_sel, data_in, miso,
    input  mosi, sck, cs_n, data_out, busy, done
  );
endinterface

// File: rtl/spi_sck_gen.sv
// SCK divider and edge counter; runs only while enabled, otherwise parks sck at idle_level_i.
module spi_sck_gen import spi_pkg::*; #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic idle_level_i,
  output logic sck_o,
  output logic lead_stb_o,
  output logic trail_stb_o,
  output logic last_edge_o
);
  localparam int unsigned EdgeW = edge_cnt_w(DATA_W);
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * DATA_W - 1);

  logic [DivW-1:0]  div_q, div_d;
  logic [EdgeW-1:0] edge_q, edge_d;
  logic             sck_q, sck_d;
  logic             tick;

  always_comb begin
    tick        = en_i && (div_q == DivLast);
    // edge_q counts edges already driven, so an even count means the next one is leading
    lead_stb_o  = tick && !edge_q[0];
    trail_stb_o = tick && edge_q[0];
    last_edge_o = tick && (edge_q == EdgeLast);
    div_d       = '0;
    edge_d      = '0;
    sck_d       = idle_level_i;
    if (en_i) begin
      div_d  = tick ? '0 : div_q + 1'b1;
      edge_d = tick ? edge_q + 1'b1 : edge_q;
      sck_d  = tick ? ~sck_q : sck_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      edge_q <= '0;
      sck_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      edge_q <= edge_d;
      sck_q  <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: transfer FSM plus tx/rx shift registers.
module spi_master_param import spi_pkg::*; #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned NUM_CS   = 1,
  parameter int unsigned CS_SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input logic                 clk,
  input logic                 rst,
  spi_master_param_if.master  bus
);
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] PhLast = DivW'(CLK_DIV - 1);

  logic [2:0]        state_q, state_d;
  logic [DivW-1:0]   ph_q, ph_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, data_out_q, data_out_d;
  logic              mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d, cs_dec;
  logic [DATA_W-1:0] tx_shift, rx_shift;
  logic              tx_bit, tx_next_bit;
  logic              sck, lead_stb, trail_stb, last_edge;

  spi_sck_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk          (clk),
    .rst          (rst),
    .en_i         (state_q == StXfer),
    .idle_level_i ((state_q == StIdle) ? bus.cpol : cpol_q),
    .sck_o        (sck),
    .lead_stb_o   (lead_stb),
    .trail_stb_o  (trail_stb),
    .last_edge_o  (last_edge)
  );

  assign tx_shift    = lsb_q ? (tx_q >> 1) : (tx_q << 1);
  assign tx_bit      = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
  assign tx_next_bit = lsb_q ? tx_q[1] : tx_q[DATA_W-2];
  assign rx_shift    = lsb_q ? {bus.miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], bus.miso};

  // Out-of-range selects match no line, so every chip select stays high.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      cs_dec[i] = (32'(bus.cs_sel) != i);
    end
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLead;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          lsb_d   = bus.lsb_first;
          tx_d    = bus.data_in;
          rx_d    = '0;
          cs_n_d  = cs_dec;
          busy_d  = 1'b1;
          if (!bus.cpha) mosi_d = bus.lsb_first ? bus.data_in[0] : bus.data_in[DATA_W-1];
        end
      end
      StLead: begin
        if (ph_q == PhLast) begin
          state_d = StXfer;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StXfer: begin
        if (lead_stb) begin
          if (cpha_q) begin
            mosi_d = tx_bit;
            tx_d   = tx_shift;
          end else begin
            rx_d = rx_shift;
          end
        end
        if (trail_stb) begin
          if (cpha_q) begin
            rx_d = rx_shift;
          end else if (!last_edge) begin
            mosi_d = tx_next_bit;
            tx_d   = tx_shift;
          end
        end
        if (last_edge) state_d = StTrail;
      end
      StTrail: begin
        if (ph_q == PhLast) begin
          state_d    = StDone;
          ph_d       = '0;
          cs_n_d     = '1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          data_out_d = rx_q;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ph_q       <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.mosi     = mosi_q;
  assign bus.sck      = sck;
  assign bus.cs_n     = cs_n_q;
  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench: 8-bit/4-CS master in loopback, 16-bit/3-CS master against an LSB-first slave.
module tb_spi_master_param;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(8), .NUM_CS(4)) bus_a ();
  spi_master_param_if #(.DATA_W(16), .NUM_CS(3)) bus_b ();

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .NUM_CS(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  assign bus_a.miso = bus_a.mosi;

  // Mode-0 slave on cs_n[0]: returns slave_word LSB-first, captures mosi LSB-first.
  logic        miso_b = 1'b0;
  logic [15:0] slave_word = 16'h1234;
  logic [15:0] s_rx = '0;
  int          s_bit = 0;
  assign bus_b.miso = miso_b;

  always @(negedge bus_b.cs_n[0]) begin
    s_bit  = 1;
    miso_b = slave_word[0];
    s_rx   = '0;
  end

  always @(negedge bus_b.sck) begin
    if (bus_b.cs_n[0] == 1'b0 && s_bit < 16) begin
      miso_b = slave_word[s_bit];
      s_bit++;
    end
  end

  always @(posedge bus_b.sck) begin
    if (bus_b.cs_n[0] == 1'b0) s_rx = {bus_b.mosi, s_rx[15:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one 8-bit transfer and observes 45 cycles (cycle n = value seen by edge T+n).
  task automatic xfer_a(input logic [1:0] mode, input logic lsbf, input logic [1:0] sel,
                        input logic [7:0] din, input bit restart, output logic [7:0] dout,
                        output int done_n, output int n_done, output bit frame_ok,
                        output bit sck_ok);
    logic [3:0] cs_exp;
    cs_exp      = 4'hF;
    cs_exp[sel] = 1'b0;
    dout = '0; done_n = 0; n_done = 0; frame_ok = 1'b1; sck_ok = 1'b1;
    @(negedge clk);
    bus_a.cpol      = mode[1];
    bus_a.cpha      = mode[0];
    bus_a.lsb_first = lsbf;
    bus_a.cs_sel    = sel;
    bus_a.data_in   = din;
    bus_a.start     = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      bus_a.start = restart && (n == 10);
      if (restart && n == 10) begin
        bus_a.data_in = 8'h3C;
        bus_a.cpha    = ~mode[0];
        bus_a.cs_sel  = sel + 2'd1;
      end
      if (bus_a.done) begin
        n_done++;
        if (done_n == 0) begin
          done_n = n;
          dout   = bus_a.data_out;
        end
      end
      if (n <= 36 && (bus_a.cs_n !== cs_exp || bus_a.busy !== 1'b1)) frame_ok = 1'b0;
      if (n >= 37 && (bus_a.cs_n !== 4'hF || bus_a.busy !== 1'b0)) frame_ok = 1'b0;
      if ((n <= 2 || (n >= 35 && n <= 37)) && bus_a.sck !== mode[1]) sck_ok = 1'b0;
    end
    bus_a.start = 1'b0;
  endtask

  task automatic xfer_b(input logic [1:0] sel, input logic [15:0] din, output logic [15:0] dout,
                        output int done_n, output int n_done, output logic mosi0,
                        output bit cs_ok);
    logic [2:0] cs_exp;
    cs_exp = 3'b111;
    if (sel < 2'd3) cs_exp[sel] = 1'b0;
    dout = '0; done_n = 0; n_done = 0; mosi0 = 1'bx; cs_ok = 1'b1;
    @(negedge clk);
    bus_b.cpol      = 1'b0;
    bus_b.cpha      = 1'b0;
    bus_b.lsb_first = 1'b1;
    bus_b.cs_sel    = sel;
    bus_b.data_in   = din;
    bus_b.start     = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 75; n++) begin
      @(negedge clk);
      bus_b.start = 1'b0;
      if (n == 1) mosi0 = bus_b.mosi;
      if (bus_b.done) begin
        n_done++;
        if (done_n == 0) begin
          done_n = n;
          dout   = bus_b.data_out;
        end
      end
      if (n <= 68 && bus_b.cs_n !== cs_exp) cs_ok = 1'b0;
      if (n >= 69 && bus_b.cs_n !== 3'b111) cs_ok = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  dout8;
    logic [15:0] dout16;
    logic        mosi0;
    int          done_n, n_done;
    bit          frame_ok, sck_ok;
    logic [1:0]  modes [3];
    logic [7:0]  words [3];
    logic        lsbs  [3];

    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.cpol = 1'b0; bus_a.cpha = 1'b0; bus_a.lsb_first = 1'b0;
    bus_a.cs_sel = '0; bus_a.data_in = '0;
    bus_b.start = 1'b0; bus_b.cpol = 1'b0; bus_b.cpha = 1'b0; bus_b.lsb_first = 1'b0;
    bus_b.cs_sel = '0; bus_b.data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_sck", 32'(bus_a.sck), 32'd0);
    check("rst_mosi", 32'(bus_a.mosi), 32'd0);
    check("rst_cs_n", 32'(bus_a.cs_n), 32'hF);
    check("rst_data_out", 32'(bus_a.data_out), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    rst = 1'b0;

    xfer_a(Mode0, 1'b0, 2'd0, 8'hF0, 1'b0, dout8, done_n, n_done, frame_ok, sck_ok);
    check("m0_data", 32'(dout8), 32'hF0);
    check("m0_latency", 32'(done_n), 32'd37);
    check("m0_done_count", 32'(n_done), 32'd1);
    check("m0_cs_busy_frame", 32'(frame_ok), 32'd1);
    check("m0_sck_idle", 32'(sck_ok), 32'd1);

    modes = '{Mode1, Mode2, Mode3};
    words = '{8'h55, 8'hAA, 8'h78};
    lsbs  = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      xfer_a(modes[i], lsbs[i], 2'd1, words[i], 1'b0, dout8, done_n, n_done, frame_ok, sck_ok);
      check($sformatf("mode%0d_data", i + 1), 32'(dout8), 32'(words[i]));
      check($sformatf("mode%0d_latency", i + 1), 32'(done_n), 32'd37);
      check($sformatf("mode%0d_sck_idle", i + 1), 32'(sck_ok), 32'd1);
    end

    xfer_a(Mode0, 1'b0, 2'd0, 8'hC3, 1'b1, dout8, done_n, n_done, frame_ok, sck_ok);
    check("restart_data", 32'(dout8), 32'hC3);
    check("restart_latency", 32'(done_n), 32'd37);
    check("restart_done_count", 32'(n_done), 32'd1);
    check("restart_frame", 32'(frame_ok), 32'd1);

    xfer_a(Mode0, 1'b0, 2'd2, 8'h81, 1'b0, dout8, done_n, n_done, frame_ok, sck_ok);
    check("sel2_frame", 32'(frame_ok), 32'd1);
    check("sel2_data", 32'(dout8), 32'h81);

    // Abort mid-XFER with a synchronous reset.
    @(negedge clk);
    bus_a.cpol = 1'b1; bus_a.cpha = 1'b0; bus_a.lsb_first = 1'b0;
    bus_a.cs_sel = 2'd1; bus_a.data_in = 8'h96; bus_a.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    rst = 1'b1;
    bus_a.cpol = 1'b0;
    @(negedge clk);
    check("abort_cs_n", 32'(bus_a.cs_n), 32'hF);
    check("abort_sck", 32'(bus_a.sck), 32'd0);
    check("abort_busy", 32'(bus_a.busy), 32'd0);
    check("abort_data_out", 32'(bus_a.data_out), 32'd0);
    rst = 1'b0;
    n_done = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (bus_a.done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);

    xfer_a(Mode1, 1'b0, 2'd3, 8'h5A, 1'b0, dout8, done_n, n_done, frame_ok, sck_ok);
    check("post_abort_data", 32'(dout8), 32'h5A);
    check("post_abort_latency", 32'(done_n), 32'd37);
    check("post_abort_frame", 32'(frame_ok), 32'd1);

    xfer_b(2'd0, 16'h5A5B, dout16, done_n, n_done, mosi0, frame_ok);
    check("w16_data", 32'(dout16), 32'h1234);
    check("w16_first_mosi", 32'(mosi0), 32'd1);
    check("w16_slave_rx", 32'(s_rx), 32'h5A5B);
    check("w16_latency", 32'(done_n), 32'd69);
    check("w16_cs", 32'(frame_ok), 32'd1);

    xfer_b(2'd3, 16'h00FF, dout16, done_n, n_done, mosi0, frame_ok);
    check("oor_latency", 32'(done_n), 32'd69);
    check("oor_done_count", 32'(n_done), 32'd1);
    check("oor_no_cs", 32'(frame_ok), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
